// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    localparam int FETCH_W = 32;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with enable and synchronous clear.
module sat_cnt #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and the MEM-stage data port.
// Optional stall-cycle counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N    = 64,
    parameter int W    = 32,
    parameter int MAXD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [W-1:0]       if_addr,
    output logic [FETCH_W-1:0] if_rdata,
    output logic               if_valid,
    output logic               if_wait,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [W-1:0]       d_addr,
    input  logic [N-1:0]       d_wdata,
    output logic [N-1:0]       d_rdata,
    output logic               d_valid,
    output logic               d_wait,
    output logic               mem_req,
    output logic               mem_we,
    output logic [W-1:0]       mem_addr,
    output logic [N-1:0]       mem_wdata,
    input  logic [N-1:0]       mem_rdata,
    input  logic               mem_ready
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_if_stall,
    output logic [31:0]        perf_d_stall
`endif
);

    localparam int SW = $clog2(MAXD + 1);

    arb_state_t    state;
    logic [SW-1:0] streak;
    logic          any_valid;
    logic          take_d;
    logic          take_i;

    // A completion pulse occupies one idle cycle, so the requester that just
    // finished has dropped its req before any new grant is considered.
    assign any_valid = if_valid | d_valid;
    assign take_d    = (state == IDLE) && !any_valid && d_req &&
                       (!if_req || (streak < SW'(MAXD)));
    assign take_i    = (state == IDLE) && !any_valid && if_req && !take_d;

    assign if_wait = if_req & ~if_valid;
    assign d_wait  = d_req & ~d_valid;

    sat_cnt #(
        .WIDTH (SW),
        .MAX   (SW'(MAXD))
    ) u_streak (
        .clk   (clk),
        .reset (reset),
        .clr   (take_i),
        .en    (take_d && if_req),
        .count (streak)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= BUSY_D;
                    end else if (take_i) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        state    <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_rdata <= mem_addr[2] ? mem_rdata[2*FETCH_W-1:FETCH_W]
                                                : mem_rdata[FETCH_W-1:0];
                        state    <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        d_rdata <= mem_rdata;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    sat_cnt #(
        .WIDTH (32)
    ) u_perf_if (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (if_wait),
        .count (perf_if_stall)
    );

    sat_cnt #(
        .WIDTH (32)
    ) u_perf_d (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (d_wait),
        .count (perf_d_stall)
    );
`else
    // Default build carries no stall counters.
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-port memory between the 5-stage pipeline's instruction-fetch port and its MEM-stage data port.
- Sequences each memory access through a req/ready handshake and returns read data to the requester.
- Produces per-port wait signals, which the hazard unit ORs into StallF and into the M/W stall.
- Data port has priority; a streak limit bounds fetch starvation.

Parameters:
N, 64, memory/data word width
W, 32, address width
MAXD, 4, max consecutive data grants while a fetch is pending (≥1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  W  fetch byte address (word aligned)
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
if_wait  out  1  if_req & ~if_valid
d_req  in  1  data request, held until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  W  data byte address
d_wdata  in  N  store data
d_rdata  out  N  load data
d_valid  out  1  one-cycle data completion pulse
d_wait  out  1  d_req & ~d_valid
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  W  memory address, registered
mem_wdata  out  N  memory write data, registered
mem_rdata  in  N  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, one cycle

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; rdata registers 0; streak counter 0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, data grant: if d_req and (!if_req or streak<MAXD), latch d_we/d_addr/d_wdata into mem_*, set mem_req=1, go to BUSY_D.
- IDLE, fetch grant: else if if_req, latch if_addr with mem_we=0, set mem_req=1, go to BUSY_I.
- IDLE, no request: stay in IDLE.
- Streak counter: +1 (saturating at MAXD) on a data grant taken while if_req=1; cleared on every fetch grant; unchanged on a data grant with if_req=0.
- BUSY_x: hold mem_* stable while mem_ready=0.
- BUSY_x, completion: on mem_ready, clear mem_req, return to IDLE, and in the next cycle pulse the matching valid for exactly one cycle with rdata registered.
- Fetch data select: if_rdata = mem_rdata[31:0] when if_addr[2]=0, else mem_rdata[63:32].
- Store data return: d_rdata on a store is undefined; the test bench does not check it.
- Latency: request high in cycle t → mem_req at t+1 → mem_ready at t+k (k≥1) → valid at t+k+1. No back-to-back accesses, so minimum period is 3 cycles.
- Simultaneous requests: data wins unless the streak limit is reached, in which case fetch wins.
- Requester drops req mid-access: the access still completes and valid still pulses; a new grant is evaluated only from IDLE.
- mem_ready in IDLE: ignored.
- Reset mid-access: the in-flight transaction is abandoned; a late mem_ready after reset is ignored because the FSM is in IDLE.
- Valid suppresses wait: valid high forces the matching wait low in the same cycle, so the pipeline advances.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- With the macro: adds outputs perf_if_stall (32 bits) and perf_d_stall (32 bits). They count cycles with if_wait and d_wait high respectively, saturate at 0xFFFFFFFF, and reset to 0.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, BUSY_I, BUSY_D};
  - constant FETCH_W = 32.
- Sub-module sat_cnt (parameterised width, enable, synchronous clear) implements the streak counter and both perf counters.

Test Plan:
1. Fetch only: if_addr=0x04, memory returns 64'h11112222_33334444 with k=2 → mem_req at t+1; if_valid at t+3 with if_rdata=0x11112222 (addr[2]=1).
2. Load: d_req, d_we=0, d_addr=0x40, memory returns 64'hDEAD_BEEF_0000_0001 → d_valid for one cycle with that value; d_wait=1 on every prior cycle.
3. Store: d_we=1, d_wdata=64'h5 → mem_we=1, mem_wdata=5, mem_addr=0x40 held stable across 3 mem_ready-low cycles.
4. Contention: if_req and d_req held high continuously, MAXD=4 → grant order D,D,D,D,I,D,D,D,D,I; fetch never waits more than 4 data accesses.
5. Reset mid-access: assert reset in BUSY_D, then mem_ready 1 cycle later → no d_valid; mem_req=0; state IDLE; next request served normally.
6. With MEM_ARB_PERF_CNT_EN: 10 cycles of if_wait → perf_if_stall=10; a reset clears it to 0.
